// File: rtl/mem_port_arbiter.sv
// Shares the off-core memory port between the I-cache refill path and the D-cache refill/write-back path.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build gives the data side fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    // Handshake: a requester raises req and holds it, with stable address/data, until
    // it sees its one-cycle ack; address, we and wdata are only sampled in the grant
    // cycle, and a request is never aborted once granted, even if req drops.

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;
    logic             any_req;
    logic             grant_d;

    assign any_req   = i_req | d_req;
    assign state_dbg = state;

`ifdef MEM_ARB_RR_EN
    // 0 = instruction side granted last, so the data side wins the first tie.
    logic last_grant_d;

    assign grant_d = d_req & (~i_req | ~last_grant_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d <= 1'b0;
        end else if (state == ST_IDLE && any_req) begin
            last_grant_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_d   <= grant_d;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_we    <= grant_d & d_we;
                        mem_en    <= 1'b1;
                        cnt       <= CNT_LOAD;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_d) begin
                            // Write-backs leave the previous read line in d_rdata.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                            d_ack <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_ACK: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    i_ack  <= 1'b0;
                    d_ack  <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboarded memory model, and directed
// sequences for ties, reset mid-access and the single-cycle latency build.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    typedef struct packed {
        logic         is_d;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    typedef struct {
        logic         is_d;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic         exp_mem_we;
        int           exp_ack_ofs;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (MEM_LATENCY = 4)
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0;
    logic [127:0] d_wdata = '0, mem_rdata = '0;
    logic         i_ack, d_ack, mem_en, mem_we;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0]  mem_addr;
    logic [1:0]   state_dbg;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
    );

    // second DUT with MEM_LATENCY = 1
    logic         i_req1 = 1'b0;
    logic [31:0]  i_addr1 = 32'h800;
    logic         i_ack1, d_ack1, mem_en1, mem_we1;
    logic [127:0] i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [31:0]  mem_addr1;
    logic [1:0]   state_dbg1;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(128'h0),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .state_dbg(state_dbg1)
    );

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a + 32'h1111_1111, a ^ 32'hdead_beef};
    endfunction

    assign mem_rdata1 = mem_en1 ? line_of(mem_addr1) : 128'h0;

    // scoreboard
    txn_t         exp_q[$];
    txn_t         cur;
    int           n_checks = 0;
    int           n_fail = 0;
    int           en_run = 0;
    logic         prev_ack = 1'b0;
    logic         last_side = 1'b0;
    logic [127:0] d_rdata_exp = '0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // memory model + monitor: rdata is only meaningful in the last mem_en cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            en_run   = 0;
            prev_ack = 1'b0;
        end else begin
            if (mem_en) begin
                en_run++;
                if (exp_q.size() == 0) begin
                    check("mem_en_unexpected", 1'b1, 1'b0);
                end else begin
                    cur = exp_q[0];
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_we", mem_we, cur.we);
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
                mem_rdata = (en_run == LAT) ? line_of(mem_addr) : {4{$urandom()}};
            end else begin
                check("mem_we_idle", mem_we, 1'b0);
                mem_rdata = {4{$urandom()}};
            end
            if (i_ack || d_ack) begin
                check("ack_single_cycle", prev_ack, 1'b0);
                check("ack_exclusive", i_ack && d_ack, 1'b0);
                check("ack_state", state_dbg, 2'd2);
                check("mem_en_run", en_run, LAT);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 1'b1, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    check("ack_side", d_ack, cur.is_d);
                    if (cur.is_d) begin
                        if (cur.we) begin
                            check("d_rdata_hold", d_rdata, d_rdata_exp);
                        end else begin
                            check("d_rdata", d_rdata, cur.rdata);
                            d_rdata_exp = cur.rdata;
                        end
                    end else begin
                        check("i_rdata", i_rdata, cur.rdata);
                    end
                    last_side = cur.is_d;
                end
                en_run = 0;
            end
            prev_ack = i_ack || d_ack;
        end
    end

    // driver tasks
    task automatic push_txn(input logic is_d, input logic we, input logic [31:0] a, input logic [127:0] wd);
        txn_t t;
        t.is_d  = is_d;
        t.we    = is_d & we;
        t.addr  = a;
        t.wdata = wd;
        t.rdata = (is_d & we) ? 128'h0 : line_of(a);
        exp_q.push_back(t);
    endtask

    task automatic wait_ack(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic logic first_winner();
`ifdef MEM_ARB_RR_EN
        return ~last_side;
`else
        return 1'b1;
`endif
    endfunction

    vec_t vecs[7];
    int   c0, c1, at;
    logic w;
    logic sides[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 128'h0, 1'b0, LAT + 1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, {16{8'hA5}}, 1'b1, LAT + 1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 128'h0, 1'b0, LAT + 1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0000, {128{1'b1}}, 1'b1, LAT + 1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0400, 128'h0, 1'b0, LAT + 1};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 128'h0, 1'b0, LAT + 1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 128'h0, 1'b0, LAT + 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_i_ack", i_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_i_rdata", i_rdata, 128'h0);
        check("rst_d_rdata", d_rdata, 128'h0);
        check("rst_state", state_dbg, 2'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // table-driven single requests; inputs are scrambled after grant
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            i_req   = ~vecs[v].is_d;
            d_req   = vecs[v].is_d;
            d_we    = vecs[v].we;
            i_addr  = vecs[v].addr;
            d_addr  = vecs[v].addr;
            d_wdata = vecs[v].wdata;
            push_txn(vecs[v].is_d, vecs[v].exp_mem_we, vecs[v].addr, vecs[v].wdata);
            c0 = cyc;
            @(posedge clk); #1;
            i_addr  = $urandom();
            d_addr  = $urandom();
            d_wdata = {4{$urandom()}};
            d_we    = 1'($urandom_range(0, 1));
            wait_ack(20, at);
            check("vec_ack_cycle", at, c0 + vecs[v].exp_ack_ofs);
            i_req = 1'b0;
            d_req = 1'b0;
        end

        // simultaneous requests, loser re-granted right after the winner
        @(posedge clk); #1;
        w = first_winner();
        i_req = 1'b1; i_addr = 32'h600;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        push_txn(w, 1'b0, w ? 32'h500 : 32'h600, 128'h0);
        push_txn(~w, 1'b0, w ? 32'h600 : 32'h500, 128'h0);
        c0 = cyc;
        wait_ack(20, at);
        check("tie_first_ack", at, c0 + LAT + 1);
        check("tie_first_side", d_ack, w);
        if (w) d_req = 1'b0; else i_req = 1'b0;
        wait_ack(20, at);
        check("tie_second_ack", at, c0 + 2 * LAT + 3);
        i_req = 1'b0; d_req = 1'b0;

        // both requesters held for four grants
        @(posedge clk); #1;
        w = first_winner();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            sides[k] = (k % 2 == 0) ? w : ~w;
`else
            sides[k] = 1'b1;
`endif
            push_txn(sides[k], 1'b0, sides[k] ? 32'h500 : 32'h600, 128'h0);
        end
        i_req = 1'b1; d_req = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_ack(20, at);
            check("stream_ack_cycle", at, c0 + k * (LAT + 2) + LAT + 1);
        end
        i_req = 1'b0; d_req = 1'b0;

        // reset in the second cycle of an access
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h700;
        push_txn(1'b0, 1'b0, 32'h700, 128'h0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("arst_mem_en", mem_en, 1'b0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_i_ack", i_ack, 1'b0);
        check("arst_i_rdata", i_rdata, 128'h0);
        check("arst_d_rdata", d_rdata, 128'h0);
        check("arst_state", state_dbg, 2'd0);
        exp_q.delete();
        d_rdata_exp = '0;
        push_txn(1'b0, 1'b0, 32'h700, 128'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        c1 = cyc;
        wait_ack(20, at);
        check("arst_regrant_ack", at, c1 + LAT + 1);
        i_req = 1'b0;

        // MEM_LATENCY = 1: grants every 3 cycles
        @(posedge clk); #1;
        i_req1 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("lat1_mem_en", mem_en1, (k % 3) == 1);
            check("lat1_i_ack", i_ack1, (k % 3) == 2);
            if (mem_en1) check("lat1_mem_addr", mem_addr1, 32'h800);
            if (i_ack1) check("lat1_i_rdata", i_rdata1, line_of(32'h800));
        end
        i_req1 = 1'b0;

        repeat (4) @(posedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single off-core memory port between the instruction-cache refill path and the data-cache refill/write-back path. It grants one requester at a time, drives the memory port for a fixed access latency and returns a one-cycle acknowledge with line data. The cache-side wait conditions it creates, request held with no acknowledge, feed the pipeline's `f_imem_stall` and `m_dmem_stall` inputs.

## Interface
- `ADDR_W`, default 32: byte address width.
- `LINE_W`, default 128: cache line width in bits.
- `MEM_LATENCY`, default 4: cycles `mem_en` is held per access; legal range 1 to 255.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `i_req  input  1`: instruction-cache line-read request; level, held until `i_ack`.
- `i_addr  input  ADDR_W`: instruction line address, sampled at grant.
- `i_ack  output  1`: one-cycle completion pulse for the instruction request.
- `i_rdata  output  LINE_W`: instruction line data, valid while `i_ack`=1.
- `d_req  input  1`: data-cache request; level, held until `d_ack`.
- `d_we  input  1`: 1 means write-back, 0 means line read; sampled at grant.
- `d_addr  input  ADDR_W`: data line address, sampled at grant.
- `d_wdata  input  LINE_W`: write-back line, sampled at grant.
- `d_ack  output  1`: one-cycle completion pulse for the data request.
- `d_rdata  output  LINE_W`: data line, valid while `d_ack`=1 after a read.
- `mem_en  output  1`: memory access active.
- `mem_we  output  1`: memory write strobe.
- `mem_addr  output  ADDR_W`: latched access address.
- `mem_wdata  output  LINE_W`: latched write line.
- `mem_rdata  input  LINE_W`: memory read data, valid in the last `mem_en` cycle.

## Operation
- The FSM has three states: IDLE, ACCESS and ACK. Reset enters IDLE.
- **IDLE:**
  - If any request is high, grant one of them per the priority rule.
  - Latch the granted requester's address and write data. Latch `we`; it is forced to 0 for the instruction path.
  - Record the grant owner.
  - Load the counter with `MEM_LATENCY-1` and go to ACCESS.
- **ACCESS:**
  - `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` come from the latches.
  - The counter decrements each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's rdata register. The capture is skipped for writes, so `d_rdata` keeps its prior value.
  - Then assert the owner's ack register and go to ACK.
- **ACK:**
  - The owner's ack is 1 for exactly this cycle.
  - Requests are not sampled in this state.
  - Next state is IDLE.
- **Priority (default):** `d_req` beats `i_req` when both are high in IDLE.
- **Request withdrawal:** dropping `req` after grant does not abort. The access completes and the ack still pulses. Requesters must not withdraw.
- **Sampling:** inputs other than `req` are ignored after the grant cycle.
- **Counter width:** `$clog2(MEM_LATENCY+1)`. The counter never underflows; ACCESS exits at 0.

## Timing
- **Reset values:**
  - `i_ack`, `d_ack`, `mem_en` and `mem_we` are 0.
  - `mem_addr`, `mem_wdata`, `i_rdata` and `d_rdata` are all zeros.
  - The state is IDLE.
- **Asynchronous reset mid-access:**
  - Outputs go to reset values immediately.
  - The in-flight access is dropped and no ack is produced.
  - Requesters re-request after reset releases.
- **Latency:** with the request sampled high in IDLE at cycle N:
  - `mem_en` is high in cycles N+1 through N+MEM_LATENCY.
  - `mem_rdata` is sampled at the end of cycle N+MEM_LATENCY.
  - The ack and rdata are presented in cycle N+MEM_LATENCY+1.
  - The FSM is back in IDLE at N+MEM_LATENCY+2, which is the earliest next grant.
- **Throughput:** one access per `MEM_LATENCY`+2 cycles.
- **Output registers:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **`MEM_ARB_RR_EN` defined:**
  - The tie-break between simultaneous requests is round-robin via a `last_grant` register; it resets to "instruction", so the data side wins the first tie.
  - On a tie, the requester not granted last wins.
  - `last_grant` updates on every grant.
- **`MEM_ARB_RR_EN` undefined:**
  - Fixed data-over-instruction priority.
  - No `last_grant` register exists.

## Test plan
- **Single instruction read:** with MEM_LATENCY=4, `i_req`=1 at cycle 0 with `i_addr`=0x100. Expect:
  - `mem_en`=1 in cycles 1–4 with `mem_addr`=0x100 and `mem_we`=0.
  - `i_ack`=1 only in cycle 5, with `i_rdata` equal to the `mem_rdata` value present in cycle 4.
- **Write-back:** `d_req`=1, `d_we`=1, `d_addr`=0x200, `d_wdata`=0xA5…A5. Expect:
  - `mem_we`=1 and `mem_wdata`=0xA5…A5 for 4 cycles.
  - `d_ack` pulses in cycle 5.
  - `d_rdata` is unchanged from its prior value.
- **Simultaneous requests, macro undefined:** `i_req` and `d_req` both high at cycle 0 and held. Expect:
  - Data granted first, `d_ack` at cycle 5.
  - Instruction granted at cycle 6, `i_ack` at cycle 11.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined:** both requesters re-request continuously. Expect grants to alternate D, I, D, I.
- **Reset mid-access:** assert `rst_n`=0 in cycle 2 of an access. Expect:
  - `mem_en`=0 immediately and no ack.
  - After release, the held `i_req` is granted again and acked after `MEM_LATENCY`+1 cycles.
- **MEM_LATENCY=1:** expect `mem_en` for 1 cycle and the ack in cycle 2; back-to-back grants every 3 cycles.
